// File: rtl/gf180mcu_nor_tree_filt.sv
// Pipelined wide-NOR zero detector: radix-4 registered reduction tree (NOR4 leaf,
// AND4 upper levels) followed by a saturating persistence filter on valid results.
module gf180mcu_nor_tree_filt #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned HOLD  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  output logic             ZN_RAW,
  output logic             VLD,
  output logic             ZN
);

  // Number of results produced by tree level k (level 0 is the raw input).
  function automatic int unsigned grp_cnt(input int unsigned k);
    int unsigned n;
    n = WIDTH;
    for (int unsigned i = 0; i < k; i++) n = (n + 3) / 4;
    return n;
  endfunction

  function automatic int unsigned stage_cnt();
    int unsigned n;
    int unsigned s;
    n = WIDTH;
    s = 0;
    while (n > 1) begin
      n = (n + 3) / 4;
      s++;
    end
    return (s == 0) ? 1 : s;
  endfunction

  localparam int unsigned L  = stage_cnt();
  localparam int unsigned CW = $clog2(HOLD + 1);

  logic         raw;
  logic [L-1:0] vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zn_q, zn_d;

  for (genvar s = 0; s < L; s++) begin : g_stg
    localparam int unsigned NI = grp_cnt(s);
    localparam int unsigned NO = grp_cnt(s + 1);

    logic [NI-1:0]   in_w;
    logic [4*NO-1:0] pad_w;
    logic [NO-1:0]   st_d, st_q;

    if (s == 0) begin : g_leaf
      // Leaf pads missing bits with 0 so they cannot block a zero detect.
      assign in_w  = A;
      assign pad_w = (4*NO)'(in_w);
      for (genvar g = 0; g < NO; g++) begin : g_nor
        assign st_d[g] = ~|pad_w[4*g +: 4];
      end
    end else begin : g_node
      // Upper levels pad with 1 (AND identity) via complement, zero-extend, complement.
      logic [NI-1:0] inv_w;
      assign in_w  = g_stg[s-1].st_q;
      assign inv_w = ~in_w;
      assign pad_w = ~((4*NO)'(inv_w));
      for (genvar g = 0; g < NO; g++) begin : g_and
        assign st_d[g] = &pad_w[4*g +: 4];
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) st_q <= '0;
      else     st_q <= st_d;
    end
  end

  assign raw = g_stg[L-1].st_q[0];

  // Valid bit shifts alongside the data; CLR flushes every in-flight result.
  always_comb begin
    vld_d = '0;
    if (!CLR) vld_d = L'({vld_q, EN});
  end

  // Saturating run counter, advanced only by valid results.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (vld_q[L-1]) begin
      if (!raw)                    cnt_d = '0;
      else if (cnt_q != CW'(HOLD)) cnt_d = cnt_q + CW'(1);
    end
    zn_d = (cnt_d == CW'(HOLD));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      cnt_q <= '0;
      zn_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      zn_q  <= zn_d;
    end
  end

  assign ZN_RAW = raw;
  assign VLD    = vld_q[L-1];
  assign ZN     = zn_q;

endmodule
